// File: rtl/seg_scan_pkg.sv
// Shared types and frame layout for the 7-seg/keypad scan sequencer.
// The frame is {col[1:0], digit[1:0], bcd[3:0]}, shifted MSB first.
package seg_scan_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        LATCH = 3'd3,
        DWELL = 3'd4
    } state_t;

    localparam int FRAME_W    = 8;
    localparam int COL_LSB    = 6;
    localparam int DIG_LSB    = 4;
    localparam int BCD_LSB    = 0;
    localparam int NUM_DIGITS = 4;

    // The keypad column scanned alongside a digit is that digit's own index.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] idx, input logic [3:0] bcd);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[COL_LSB +: 2] = idx;
        f[DIG_LSB +: 2] = idx;
        f[BCD_LSB +: 4] = bcd;
        return f;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-column keypad debouncer: a column's state flips only after DEB_PASSES
// consecutive samples disagree with it; one column is sampled per strobe.
module key_debounce
    import seg_scan_pkg::*;
#(
    parameter int DEB_PASSES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample,
    input  logic [1:0] col,
    input  logic       raw,
    output logic [3:0] key_state,
    output logic       key_event
);

    localparam logic [2:0] DEB_LIM = 3'(DEB_PASSES);

    logic [2:0] cnt_q [NUM_DIGITS];
    logic [2:0] cnt_d [NUM_DIGITS];
    logic [3:0] key_state_q, key_state_d;
    logic       key_event_q, key_event_d;

    always_comb begin
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        key_event_d = 1'b0;
        if (sample) begin
            if (raw == key_state_q[col]) begin
                cnt_d[col] = '0;
            end else if (cnt_q[col] + 3'd1 == DEB_LIM) begin
                key_state_d[col] = ~key_state_q[col];
                cnt_d[col]       = '0;
                key_event_d      = 1'b1;
            end else begin
                cnt_d[col] = cnt_q[col] + 3'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt_q[gi] <= '0;
                else     cnt_q[gi] <= cnt_d[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state_q <= '0;
            key_event_q <= 1'b0;
        end else begin
            key_state_q <= key_state_d;
            key_event_q <= key_event_d;
        end
    end

    assign key_state = key_state_q;
    assign key_event = key_event_q;

endmodule

// File: rtl/seg_scan_sequencer.sv
// Serial master that round-robins the four digit frames into the external
// 7-seg/keypad decoder and samples one keypad column per frame.
module seg_scan_sequencer
    import seg_scan_pkg::*;
#(
    parameter int DWELL_CYC  = 256,
    parameter int DWELL_W    = 9,
    parameter int DEB_PASSES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       spi_mosi,
    output logic       spi_en,
    input  logic       spi_miso,
    output logic [1:0] digit_idx,
    output logic       busy,
    output logic [3:0] key_state,
    output logic       key_event
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   sr_q, sr_d;
    logic [2:0]           bit_q, bit_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [1:0]           idx_q, idx_d;
    logic                 spi_en_q, spi_en_d;
    logic [3:0]           digit_q [NUM_DIGITS];
    logic [3:0]           digit_d [NUM_DIGITS];
    logic                 sample;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_d[gi] = (wr_en && wr_addr == 2'(gi)) ? wr_data : digit_q[gi];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) digit_q[gi] <= '0;
                else     digit_q[gi] <= digit_d[gi];
            end
        end
    endgenerate

    // The shift register drives MOSI straight from its MSB; after eight shifts it
    // has emptied itself, so MOSI is already 0 in LATCH and DWELL.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        dwell_d  = dwell_q;
        idx_d    = idx_q;
        spi_en_d = 1'b0;
        sample   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = LOAD;
            end
            LOAD: begin
                sr_d     = build_frame(idx_q, digit_q[idx_q]);
                bit_d    = '0;
                spi_en_d = 1'b1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                sr_d  = sr_q << 1;
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = LATCH;
                else               spi_en_d = 1'b1;
            end
            LATCH: begin
                dwell_d = '0;
                state_d = DWELL;
            end
            DWELL: begin
                dwell_d = dwell_q + DWELL_W'(1);
                if (dwell_q == DWELL_LAST) begin
                    sample  = 1'b1;
                    idx_d   = idx_q + 2'd1;
                    state_d = run ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bit_q    <= '0;
            dwell_q  <= '0;
            idx_q    <= '0;
            spi_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bit_q    <= bit_d;
            dwell_q  <= dwell_d;
            idx_q    <= idx_d;
            spi_en_q <= spi_en_d;
        end
    end

    key_debounce #(
        .DEB_PASSES(DEB_PASSES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .sample    (sample),
        .col       (idx_q),
        .raw       (~spi_miso),
        .key_state (key_state),
        .key_event (key_event)
    );

    assign spi_mosi  = sr_q[FRAME_W-1];
    assign spi_en    = spi_en_q;
    assign digit_idx = idx_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seg_scan_sequencer.sv
// Scoreboard bench: stimulus queues expected decoder frames and key changes,
// a decoder/keypad model on the serial pins pops and compares them.
module tb_seg_scan_sequencer;

    localparam int DWELL_CYC = 4;
    localparam int DEB       = 2;
    localparam int PERIOD    = 10 + DWELL_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       spi_mosi;
    logic       spi_en;
    logic       spi_miso;
    logic [1:0] digit_idx;
    logic       busy;
    logic [3:0] key_state;
    logic       key_event;

    seg_scan_sequencer #(
        .DWELL_CYC (DWELL_CYC),
        .DWELL_W   (3),
        .DEB_PASSES(DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .spi_mosi  (spi_mosi),
        .spi_en    (spi_en),
        .spi_miso  (spi_miso),
        .digit_idx (digit_idx),
        .busy      (busy),
        .key_state (key_state),
        .key_event (key_event)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- scoreboard shared state ----------------
    logic [7:0] exp_frames [$];
    logic [3:0] exp_keys   [$];
    logic [3:0] pat   [0:1023];   // keys held down during each frame since reset
    int         stamp [0:1023];   // cycle at which each frame was latched
    int         lat_cnt = 0;

    // ---------------- decoder + keypad model / monitor ----------------
    logic [7:0] shreg   = '0;
    logic       prev_en = 1'b0;
    int         en_cnt  = 0;
    logic [1:0] cur_col = '0;
    logic [3:0] cur_pat = '0;

    assign spi_miso = ~cur_pat[cur_col];

    always @(negedge clk) begin
        if (rst) begin
            shreg   = '0;
            prev_en = 1'b0;
            en_cnt  = 0;
            lat_cnt = 0;
            cur_col = '0;
            cur_pat = '0;
        end else begin
            if (spi_en) begin
                shreg = {shreg[6:0], spi_mosi};
                en_cnt++;
            end else if (prev_en) begin
                stamp[lat_cnt] = cyc;
                cur_col = shreg[7:6];
                cur_pat = pat[lat_cnt];
                if (exp_frames.size() == 0) fail_now("frame_unexpected");
                else chk("latched_frame", shreg, exp_frames.pop_front());
                chk("en_high_cycles", en_cnt, 8);
                en_cnt = 0;
                lat_cnt++;
            end
            prev_en = spi_en;
            if (key_event) begin
                if (exp_keys.size() == 0) fail_now("key_event_unexpected");
                else chk("key_state_on_event", key_state, exp_keys.pop_front());
            end
        end
    end

    // ---------------- reference model (stimulus side) ----------------
    logic [3:0] mdig [4];
    logic [1:0] m_idx;
    int         g_frame;
    logic [3:0] m_key;
    int         m_cnt [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mdig[i]  = '0;
            m_cnt[i] = 0;
        end
        m_idx   = '0;
        g_frame = 0;
        m_key   = '0;
    endtask

    // Expected result of the next frame: latched byte, then the keypad decision.
    task automatic push_frame();
        logic [1:0] c;
        logic       s;
        c = m_idx;
        exp_frames.push_back({c, c, mdig[c]});
        s = pat[g_frame][c];
        if (s == m_key[c]) begin
            m_cnt[c] = 0;
        end else begin
            m_cnt[c]++;
            if (m_cnt[c] == DEB) begin
                m_key[c] = ~m_key[c];
                m_cnt[c] = 0;
                exp_keys.push_back(m_key);
            end
        end
        g_frame++;
        m_idx = m_idx + 2'd1;
    endtask

    task automatic write_digit(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        mdig[a] = d;
    endtask

    task automatic wait_en_high();
        int t = 0;
        while (spi_en !== 1'b1 && t < 100) begin
            @(negedge clk); #1; t++;
        end
        chk("wait_spi_en_high", spi_en, 1);
    endtask

    task automatic wait_latches(input int target);
        int t = 0;
        int budget;
        budget = (target - lat_cnt) * PERIOD + 40;
        while (lat_cnt < target && t < budget) begin
            @(negedge clk); #1; t++;
        end
        chk("latch_count", lat_cnt, target);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 4 * PERIOD) begin
            @(negedge clk); #1; t++;
        end
        chk("reach_idle_busy", busy, 0);
    endtask

    // Runs exactly n frames back to back, then lets the sequencer go idle.
    task automatic run_frames(input int n);
        int base;
        base = lat_cnt;
        for (int i = 0; i < n; i++) push_frame();
        run = 1'b1;
        wait_latches(base + n);
        run = 1'b0;
        wait_idle();
        for (int i = base + 1; i < base + n; i++)
            chk("frame_period", stamp[i] - stamp[i-1], PERIOD);
        chk("digit_idx_after_run", digit_idx, m_idx);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [3:0] held, p;
        int n;

        rst = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 1024; i++) pat[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a shift
        write_digit(0, 4'd9);
        write_digit(1, 4'd9);
        run = 1'b1;
        wait_en_high();
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_spi_en", spi_en, 0);
        chk("rst_spi_mosi", spi_mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_digit_idx", digit_idx, 0);
        chk("rst_key_state", key_state, 0);
        chk("rst_key_event", key_event, 0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (6) @(negedge clk);
        chk("idle_after_reset_busy", busy, 0);
        chk("idle_after_reset_en", spi_en, 0);

        // Single frame of digit0 = 5
        write_digit(0, 4'd5);
        run_frames(1);

        // Drop run while digit1 (cleared by reset) is shifting
        push_frame();
        base = lat_cnt;
        run = 1'b1;
        wait_en_high();
        run = 1'b0;
        wait_latches(base + 1);
        wait_idle();
        chk("run_drop_digit_idx", digit_idx, 2);

        // Full scan with wrap: 06,57,A8,F9,06 starting from digit 0
        write_digit(0, 4'd6);
        write_digit(1, 4'd7);
        write_digit(2, 4'd8);
        write_digit(3, 4'd9);
        run_frames(2);
        run_frames(5);

        // Rewrite digit1 while its frame is in flight
        push_frame();
        base = lat_cnt;
        run = 1'b1;
        wait_en_high();
        write_digit(1, 4'd3);
        repeat (4) push_frame();
        wait_latches(base + 5);
        run = 1'b0;
        wait_idle();

        // Column 2 press, single-sample glitch, release
        for (int i = 0; i < 24; i++)
            pat[g_frame + i] = (i < 8 || (i >= 12 && i < 16)) ? 4'b0100 : 4'b0000;
        run_frames(24);
        chk("keys_released", key_state, 0);

        // Randomised digits and key traffic
        for (int r = 0; r < 5; r++) begin
            for (int d = 0; d < 4; d++) write_digit(2'(d), 4'($urandom_range(0, 15)));
            n = $urandom_range(4, 14);
            held = 4'($urandom_range(0, 15));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 5) == 0) held = 4'($urandom_range(0, 15));
                p = held;
                if ($urandom_range(0, 7) == 0) p = p ^ (4'b0001 << $urandom_range(0, 3));
                pat[g_frame + i] = p;
            end
            run_frames(n);
        end

        repeat (4) @(negedge clk);
        chk("frames_left", exp_frames.size(), 0);
        chk("key_events_left", exp_keys.size(), 0);
        chk("final_key_state", key_state, m_key);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
